// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle signed 16x16 multiply and 16/16 divide.
// Runs a 16-iteration shift-add (MUL) or restoring-divide (DIV) loop on operand
// magnitudes, then applies the signs in a FIXUP cycle. result = {hi/rem, lo/quo}.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_sys,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] result,
    output logic        div0
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        op_q, op_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [16:0] mag_a_q, mag_a_d;
    logic [16:0] mag_b_q, mag_b_d;
    logic [31:0] acc_q, acc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        div0_q, div0_d;
    logic [31:0] result_q, result_d;

    logic [16:0] mag_a_in, mag_b_in;
    logic [16:0] mul_sum;
    logic [31:0] mul_shift;
    logic [16:0] rem_sh;
    logic        div_ge;
    logic [15:0] div_diff;
    logic        neg;
    logic [15:0] quo_fix, rem_fix;

    // 17-bit magnitudes so that -32768 becomes +32768 without overflow.
    assign mag_a_in = a[15] ? (17'd0 - {1'b1, a}) : {1'b0, a};
    assign mag_b_in = b[15] ? (17'd0 - {1'b1, b}) : {1'b0, b};

    // Shift-add step: conditionally add |a| into the high half, then shift the
    // 33-bit {carry, acc} right by one.
    assign mul_sum   = {1'b0, acc_q[31:16]} + (acc_q[0] ? mag_a_q : 17'd0);
    assign mul_shift = {mul_sum, acc_q[15:1]};

    // Restoring-divide step: {rem, quo} << 1, then trial subtract |b|. The
    // remainder stays below |b| <= 32768, so the kept difference fits 16 bits.
    assign rem_sh   = acc_q[31:15];
    assign div_ge   = (rem_sh >= mag_b_q);
    assign div_diff = rem_sh[15:0] - mag_b_q[15:0];

    assign neg     = sign_a_q ^ sign_b_q;
    assign quo_fix = neg ? (16'd0 - acc_q[15:0]) : acc_q[15:0];
    assign rem_fix = sign_a_q ? (16'd0 - acc_q[31:16]) : acc_q[31:16];

    // Next-state and datapath control for the IDLE/CALC/FIXUP sequencer.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        div0_d   = div0_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op && (b == '0)) begin
                        done_d   = 1'b1;
                        div0_d   = 1'b1;
                        result_d = {a, 16'hFFFF};
                    end else begin
                        op_d     = op;
                        sign_a_d = a[15];
                        sign_b_d = b[15];
                        mag_a_d  = mag_a_in;
                        mag_b_d  = mag_b_in;
                        acc_d    = op ? {16'd0, mag_a_in[15:0]} : {16'd0, mag_b_in[15:0]};
                        count_d  = 4'd15;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (op_q) begin
                    acc_d = div_ge ? {div_diff, acc_q[14:0], 1'b1}
                                   : {rem_sh[15:0], acc_q[14:0], 1'b0};
                end else begin
                    acc_d = mul_shift;
                end
                count_d = count_q - 4'd1;
                if (count_q == 4'd0) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                if (op_q) begin
                    result_d = {rem_fix, quo_fix};
                end else begin
                    result_d = neg ? (32'd0 - acc_q) : acc_q;
                end
                done_d  = 1'b1;
                div0_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; halt_sys freezes every one of them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
            result_q <= '0;
        end else if (!halt_sys) begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
            result_q <= result_d;
        end
    end

    assign stall  = ((state_q == IDLE) && start) || (state_q != IDLE);
    assign busy   = busy_q;
    assign done   = done_q;
    assign div0   = div0_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: table-driven vectors plus hand-written
// sequences for reset abort, halt stretch and back-to-back starts.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt_sys = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, stall, done, div0;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic        d0;
        int          lat;
        int          t0;
    } exp_t;

    typedef struct {
        logic        o;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] res;
        logic        d0;
        int          hs;
        int          hl;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];

    muldiv_sequencer dut (
        .clk(clk), .rst(rst), .halt_sys(halt_sys), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .stall(stall), .done(done),
        .result(result), .div0(div0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic take_done(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: done with empty scoreboard", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_result"}, result, e.res);
            chk({nm, "_div0"}, 32'(div0), 32'(e.d0));
            chk({nm, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
        end
    endtask

    function automatic void model(input logic o, input logic [15:0] x, input logic [15:0] y,
                                  output logic [31:0] r, output logic d);
        int sx, sy, q, m;
        sx = int'($signed(x));
        sy = int'($signed(y));
        d  = 1'b0;
        if (!o) begin
            r = 32'(sx * sy);
        end else if (y == 16'd0) begin
            r = {x, 16'hFFFF};
            d = 1'b1;
        end else begin
            q = sx / sy;
            m = sx % sy;
            r = {m[15:0], q[15:0]};
        end
    endfunction

    task automatic run_op(input vec_t v, input string nm);
        int   lat;
        bit   got;
        bit   isz;
        exp_t e;
        isz = v.o && (v.b == 16'd0);
        lat = (isz ? 1 : 18) + v.hl;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(posedge clk); #1;
            start    = (k == 0);
            halt_sys = (k >= v.hs) && (k < v.hs + v.hl);
            if (k == 0) begin
                op = v.o; a = v.a; b = v.b;
                e.res = v.res; e.d0 = v.d0; e.lat = lat; e.t0 = cyc;
                sb.push_back(e);
            end
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                take_done(nm);
                chk({nm, "_stall_at_done"}, 32'(stall), 32'd0);
                chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
            end else if (k == 0 || k == lat - 1) begin
                chk({nm, "_stall"}, 32'(stall), 32'd1);
                chk({nm, "_busy"}, 32'(busy), 32'(!isz && k > 0));
            end
        end
        halt_sys = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 60 cycles", nm);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        exp_t e;
        bit   seen;
        int   got;

        vecs[0]  = '{1'b0, 16'd300,   16'd200,   32'd60000,     1'b0, 99, 0};
        vecs[1]  = '{1'b0, 16'hFFFD,  16'd7,     32'hFFFFFFEB,  1'b0, 99, 0};
        vecs[2]  = '{1'b0, 16'h8000,  16'h8000,  32'h40000000,  1'b0, 99, 0};
        vecs[3]  = '{1'b1, 16'hFFF9,  16'd2,     32'hFFFFFFFD,  1'b0, 99, 0};
        vecs[4]  = '{1'b1, 16'h1234,  16'd0,     32'h1234FFFF,  1'b1, 99, 0};
        vecs[5]  = '{1'b1, 16'h8000,  16'hFFFF,  32'h00008000,  1'b0, 99, 0};
        vecs[6]  = '{1'b0, 16'h7FFF,  16'h7FFF,  32'h3FFF0001,  1'b0, 99, 0};
        vecs[7]  = '{1'b0, 16'h8000,  16'h7FFF,  32'hC0008000,  1'b0, 99, 0};
        vecs[8]  = '{1'b1, 16'd100,   16'd7,     32'h0002000E,  1'b0, 99, 0};
        vecs[9]  = '{1'b1, 16'd7,     16'hFF9C,  32'h00070000,  1'b0, 99, 0};
        vecs[10] = '{1'b0, 16'd0,     16'h1234,  32'h00000000,  1'b0, 99, 0};
        vecs[11] = '{1'b0, 16'd1000,  16'hFF00,  32'hFFFC1800,  1'b0, 5,  3};
        vecs[12] = '{1'b1, 16'hFF9C,  16'd7,     32'hFFFEFFF2,  1'b0, 99, 0};

        // Reset state: outputs cleared, stall follows start only.
        start = 1'b1;
        #3;
        chk("rst_stall_start", 32'(stall), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_div0", 32'(div0), 32'd0);
        start = 1'b0;
        #1;
        chk("rst_stall_idle", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in mid-MUL aborts immediately with no done afterwards.
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; a = 16'd5; b = 16'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        // Back-to-back: start re-asserted in the done cycle is accepted.
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; a = 16'd3; b = 16'd4;
        e.res = 32'd12; e.d0 = 1'b0; e.lat = 18; e.t0 = cyc;
        sb.push_back(e);
        got = 0;
        for (int k = 1; k < 45 && got < 2; k++) begin
            @(posedge clk); #1;
            start = (k == 18);
            if (k == 18) begin
                op = 1'b1; a = 16'd100; b = 16'd7;
                e.res = 32'h0002000E; e.d0 = 1'b0; e.lat = 18; e.t0 = cyc;
                sb.push_back(e);
            end
            @(negedge clk);
            if (k == 18) chk("b2b_stall_restart", 32'(stall), 32'd1);
            if (done) begin
                take_done($sformatf("b2b%0d", got));
                got++;
            end
        end
        start = 1'b0;
        chk("b2b_done_count", 32'(got), 32'd2);
        sb.delete();

        // Divide by zero with halt held through the done cycle: done stretches.
        @(posedge clk); #1;
        start = 1'b1; op = 1'b1; a = 16'h00AB; b = 16'd0;
        e.res = 32'h00ABFFFF; e.d0 = 1'b1; e.lat = 1; e.t0 = cyc;
        sb.push_back(e);
        @(negedge clk);
        chk("hold_stall_c0", 32'(stall), 32'd1);
        chk("hold_busy_c0", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; halt_sys = 1'b1;
        @(negedge clk);
        chk("hold_done_c1", 32'(done), 32'd1);
        take_done("hold");
        @(posedge clk); #1;
        halt_sys = 1'b0;
        @(negedge clk);
        chk("hold_done_stretched", 32'(done), 32'd1);
        chk("hold_result_stretched", result, 32'h00ABFFFF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_done_released", 32'(done), 32'd0);
        chk("hold_div0_held", 32'(div0), 32'd1);
        chk("hold_busy_never", 32'(busy), 32'd0);

        // Random operands against the reference model.
        for (int i = 0; i < 10; i++) begin
            v.o  = 1'($urandom_range(0, 1));
            v.a  = 16'($urandom);
            v.b  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            v.hs = 99;
            v.hl = 0;
            model(v.o, v.a, v.b, v.res, v.d0);
            run_op(v, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
